// File: rtl/osc_pkg.sv
// Shared types and default sizes for the oscilloscope capture controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: capture state encoding, default RAM address width and ADC sample width.
package osc_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE_FILL  = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4,
        READ      = 3'd5
    } capt_state_t;

endpackage

// File: rtl/osc_trig_detect.sv
// Level-crossing trigger detector: remembers the previous accepted sample and flags a crossing.
// Latency: hit is combinational on the current sample; prev sample registers on each valid.
// Backpressure: none; every valid sample is consumed.
// Ports: clk, rst_n; valid/data = accepted sample; level/rising = threshold and edge;
//        clear = forget the previous sample; hit = crossing on this sample.
module osc_trig_detect #(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] level,
    input  logic              rising,
    input  logic              clear,
    output logic              hit
);

    logic [DATA_W-1:0] prev_dat;
    logic              prev_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_dat <= '0;
            prev_vld <= 1'b0;
        end else if (clear) begin
            prev_vld <= 1'b0;
        end else if (valid) begin
            prev_dat <= data;
            prev_vld <= 1'b1;
        end
    end

    // A crossing needs two consecutive accepted samples straddling the level.
    always_comb begin
        hit = 1'b0;
        if (valid && prev_vld) begin
            if (rising) hit = (prev_dat < level) && (data >= level);
            else        hit = (prev_dat > level) && (data <= level);
        end
    end

endmodule

// File: rtl/osc_capture_ctrl.sv
// Capture sequencer: circular pre-trigger fill, level trigger, post fill, freeze, ordered readout.
// Latency: RAM write registered 1 cycle after adc_valid; rd_valid 1 cycle after each read address.
// Backpressure: none; ADC samples are written or dropped by state, readout streams at one per cycle.
// Ports: arm/abort/rd_start control pulses; trig_* and pre_samples configure the capture;
//        adc_valid/adc_data in; ram_* drive the dual-port RAM; rd_valid/rd_data stream the capture;
//        trig_addr, done and busy report status.
module osc_capture_ctrl
    import osc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_rising,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [ADDR_W-1:0] pre_samples,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              rd_start,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              done,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    capt_state_t       state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] pre_r;
    logic [ADDR_W-1:0] post_r;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] rd_cnt;
    logic              capt_wr_en;
    logic              accept;
    logic              arm_ok;
    logic              read_go;
    logic              trig_hit;
    logic              trig_fire;
    logic              pre_done;

    osc_trig_detect #(.DATA_W(DATA_W)) u_trig (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (accept),
        .data   (adc_data),
        .level  (trig_level),
        .rising (trig_rising),
        .clear  (arm_ok && !abort),
        .hit    (trig_hit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Decode / outputs
    always_comb begin
        // Once the post count is exhausted, the next sample would overwrite the oldest
        // pre-trigger sample, so the last POST cycle writes nothing.
        capt_wr_en = (state == PRE_FILL) || (state == WAIT_TRIG) ||
                     ((state == POST) && (cnt != '0));
        accept     = adc_valid && capt_wr_en && !abort;
        arm_ok     = arm && ((state == IDLE) || (state == DONE));
        read_go    = rd_start && (state == DONE) && !arm;
        trig_fire  = (state == WAIT_TRIG) && trig_hit;
        // Leave as soon as the pre-th sample is written; pre=0 leaves on the first cycle.
        pre_done   = (cnt == pre_r) || (accept && ((cnt + ADDR_ONE) == pre_r));
        busy       = (state == PRE_FILL) || (state == WAIT_TRIG) ||
                     (state == POST) || (state == READ);
        rd_data    = rd_valid ? ram_rdata : '0;
    end

    // Next state; abort overrides everything.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (arm_ok) state_nxt = PRE_FILL;
                PRE_FILL:  if (pre_done) state_nxt = WAIT_TRIG;
                WAIT_TRIG: if (trig_fire) state_nxt = POST;
                POST:      if (cnt == '0) state_nxt = DONE;
                DONE: begin
                    if (arm_ok)       state_nxt = PRE_FILL;
                    else if (read_go) state_nxt = READ;
                end
                READ:      if (rd_cnt == '1) state_nxt = DONE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            cnt        <= '0;
            pre_r      <= '0;
            post_r     <= '0;
            start_addr <= '0;
            rd_cnt     <= '0;
            ram_we     <= 1'b0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            ram_raddr  <= '0;
            rd_valid   <= 1'b0;
            trig_addr  <= '0;
            done       <= 1'b0;
        end else begin
            ram_we   <= accept;
            rd_valid <= (state == READ) && !abort;
            // wr_ptr deliberately survives arm so the buffer keeps rotating between captures.
            if (accept) begin
                ram_waddr <= wr_ptr;
                ram_wdata <= adc_data;
                wr_ptr    <= wr_ptr + ADDR_ONE;
            end
            if (abort) begin
                done <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (arm_ok) begin
                            done   <= 1'b0;
                            cnt    <= '0;
                            // An ADDR_W-wide count is already at most DEPTH-1.
                            pre_r  <= pre_samples;
                            post_r <= ~pre_samples;
                        end else if (read_go) begin
                            ram_raddr <= start_addr;
                            rd_cnt    <= '0;
                        end
                    end
                    PRE_FILL: begin
                        if (accept && (cnt != pre_r)) cnt <= cnt + ADDR_ONE;
                    end
                    WAIT_TRIG: begin
                        if (trig_fire) begin
                            trig_addr <= wr_ptr;
                            cnt       <= post_r;
                        end
                    end
                    POST: begin
                        if (cnt == '0) begin
                            done       <= 1'b1;
                            start_addr <= trig_addr - pre_r;
                        end else if (accept) begin
                            cnt <= cnt - ADDR_ONE;
                        end
                    end
                    READ: begin
                        ram_raddr <= ram_raddr + ADDR_ONE;
                        rd_cnt    <= rd_cnt + ADDR_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_osc_capture_ctrl.sv
// Bench for osc_capture_ctrl with a 16-entry RAM model and a sample-stream reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_osc_capture_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 10;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm = 1'b0, abort = 1'b0, trig_rising = 1'b0, adc_valid = 1'b0, rd_start = 1'b0;
    logic [DW-1:0] trig_level = '0, adc_data = '0, ram_rdata = '0;
    logic [AW-1:0] pre_samples = '0;
    logic          ram_we, rd_valid, done, busy;
    logic [AW-1:0] ram_waddr, ram_raddr, trig_addr;
    logic [DW-1:0] ram_wdata, rd_data;

    osc_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig_rising(trig_rising),
        .trig_level(trig_level), .pre_samples(pre_samples), .adc_valid(adc_valid),
        .adc_data(adc_data), .rd_start(rd_start), .ram_rdata(ram_rdata), .ram_we(ram_we),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_raddr(ram_raddr),
        .rd_valid(rd_valid), .rd_data(rd_data), .trig_addr(trig_addr), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Dual-port RAM with 1-cycle synchronous read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        ram_rdata <= ram[ram_raddr];
    end

    int total = 0, bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation queues filled away from the active edge.
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            wc_q[$];
    logic [DW-1:0] rq[$];
    int            rvc_q[$];
    logic [AW-1:0] raq[$];
    int            nv_err = 0, first_rv = -1, read_entry = -1, done_cyc = -1;
    logic          last_valid = 1'b0, done_q = 1'b0;

    always @(posedge clk) last_valid = adc_valid;

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wa_q.push_back(ram_waddr);
            wd_q.push_back(ram_wdata);
            wc_q.push_back(cyc);
            if (!last_valid) nv_err++;
        end
        if (rd_valid === 1'b1) begin
            rq.push_back(rd_data);
            rvc_q.push_back(cyc);
            if (first_rv < 0) first_rv = cyc;
        end
        if (busy === 1'b1 && done === 1'b1) begin
            raq.push_back(ram_raddr);
            if (read_entry < 0) read_entry = cyc;
        end
        if (done === 1'b1 && done_q !== 1'b1) done_cyc = cyc;
        done_q = done;
    end

    // Reference model state: accepted-sample stream and the model write pointer.
    int stim[$];
    int base = 0;
    int exp_start = 0;
    int exp_rd[$];
    int fed = 0;

    function automatic bit crosses(int p, int c, int lvl, bit rise);
        if (rise) return (p < lvl) && (c >= lvl);
        return (p > lvl) && (c <= lvl);
    endfunction

    // Sample k is eligible once pre samples precede it and it has a predecessor.
    function automatic int find_trig(int pre, int lvl, bit rise);
        int first;
        first = (pre > 1) ? pre : 1;
        for (int k = first; k < stim.size(); k++)
            if (crosses(stim[k-1], stim[k], lvl, rise)) return k;
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic arm_capture(int pre, int lvl, bit rise);
        @(negedge clk);
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        nv_err = 0; done_cyc = -1;
        pre_samples = AW'(pre); trig_level = DW'(lvl); trig_rising = rise;
        adc_valid = 1'b0; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // mode 0: every cycle valid; 1: valid on alternate cycles; 2: random 3/4 density.
    task automatic feed(int from, int to, int mode);
        int i = from;
        int n = 0;
        while (i < to && done !== 1'b1 && n < 4000) begin
            case (mode)
                0:       adc_valid = 1'b1;
                1:       adc_valid = (n % 2 == 0);
                default: adc_valid = ($urandom_range(0, 3) != 0);
            endcase
            if (adc_valid) begin
                adc_data = DW'(stim[i]);
                i++;
            end else begin
                adc_data = DW'($urandom_range(0, 1023));
            end
            n++;
            @(negedge clk);
        end
        adc_valid = 1'b0;
        fed = i;
    endtask

    task automatic finish_capture(string tag, int pre, int k);
        int post, nw;
        repeat (3) @(negedge clk);
        post = DEPTH - 1 - pre;
        nw   = k + 1 + post;
        chk({tag, ".trig_found"}, (k >= 0), 1);
        chk({tag, ".nwrites"}, wa_q.size(), nw);
        for (int i = 0; i < nw && i < wa_q.size(); i++) begin
            chk({tag, ".waddr"}, wa_q[i], (base + i) % DEPTH);
            chk({tag, ".wdata"}, wd_q[i], stim[i]);
        end
        chk({tag, ".no_write_without_valid"}, nv_err, 0);
        chk({tag, ".trig_addr"}, trig_addr, (base + k) % DEPTH);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy_after"}, busy, 0);
        exp_start = (base + k - pre) % DEPTH;
        exp_rd.delete();
        for (int j = 0; j < DEPTH; j++) exp_rd.push_back(stim[k - pre + j]);
        base = (base + nw) % DEPTH;
    endtask

    task automatic do_read(string tag);
        @(negedge clk);
        rq.delete(); rvc_q.delete(); raq.delete();
        first_rv = -1; read_entry = -1;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        repeat (DEPTH + 4) @(negedge clk);
        chk({tag, ".n_rd_valid"}, rq.size(), DEPTH);
        chk({tag, ".n_raddr"}, raq.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < raq.size(); i++)
            chk({tag, ".raddr"}, raq[i], (exp_start + i) % DEPTH);
        for (int i = 0; i < DEPTH && i < rq.size(); i++)
            chk({tag, ".rd_data"}, rq[i], exp_rd[i]);
        if (rvc_q.size() == DEPTH) chk({tag, ".rd_contig"}, rvc_q[DEPTH-1] - rvc_q[0], DEPTH - 1);
        chk({tag, ".rd_latency"}, first_rv - read_entry, 1);
        chk({tag, ".done_kept"}, done, 1);
        chk({tag, ".busy_after"}, busy, 0);
    endtask

    task automatic ramp_capture(string tag, int pre, int lvl, int mode);
        int k;
        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back(i);
        k = find_trig(pre, lvl, 1'b1);
        arm_capture(pre, lvl, 1'b1);
        feed(0, stim.size(), mode);
        finish_capture(tag, pre, k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, pre, lvl;
        bit rise, complete;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.ram_we", ram_we, 0);
        chk("rst.ram_waddr", ram_waddr, 0);
        chk("rst.ram_wdata", ram_wdata, 0);
        chk("rst.ram_raddr", ram_raddr, 0);
        chk("rst.rd_valid", rd_valid, 0);
        chk("rst.rd_data", rd_data, 0);
        chk("rst.trig_addr", trig_addr, 0);
        chk("rst.done", done, 0);
        chk("rst.busy", busy, 0);
        rst_n = 1'b1;

        // Dense ramp, rising at 10, four pre samples; then read twice.
        ramp_capture("ramp", 4, 10, 0);
        chk("ramp.trig_addr_abs", trig_addr, 10);
        chk("ramp.start_abs", exp_start, 6);
        do_read("ramp.read");
        do_read("ramp.reread");

        // Falling trigger on a descending ramp.
        stim.delete();
        for (int i = 0; i < 30; i++) stim.push_back(i < 10 ? 9 - i : int'($urandom_range(0, 1023)));
        k = find_trig(2, 5, 1'b0);
        arm_capture(2, 5, 1'b0);
        feed(0, stim.size(), 0);
        finish_capture("fall", 2, k);
        do_read("fall.read");

        // Data already below the level never triggers; arm in WAIT_TRIG is ignored.
        stim.delete();
        for (int i = 0; i < 30; i++) stim.push_back(int'($urandom_range(0, 3)));
        stim.push_back(8);
        stim.push_back(4);
        for (int i = 0; i < 20; i++) stim.push_back(int'($urandom_range(0, 3)));
        k = find_trig(3, 5, 1'b0);
        arm_capture(3, 5, 1'b0);
        feed(0, 30, 0);
        repeat (2) @(negedge clk);
        chk("notrig.busy", busy, 1);
        chk("notrig.done", done, 0);
        pre_samples = AW'(12);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        feed(30, stim.size(), 0);
        finish_capture("notrig_then_trig", 3, k);

        // pre=0: trigger sample is the oldest in the readout.
        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back(i == 5 ? 600 : int'($urandom_range(0, 99)));
        k = find_trig(0, 500, 1'b1);
        arm_capture(0, 500, 1'b1);
        feed(0, stim.size(), 0);
        finish_capture("pre0", 0, k);
        do_read("pre0.read");

        // pre=15: done the cycle after the trigger write.
        ramp_capture("pre15", 15, 20, 0);
        if (wc_q.size() > 20) chk("pre15.done_after_trig_write", done_cyc - wc_q[20], 1);
        do_read("pre15.read");

        // Sparse valid: same relative addresses, no write on idle cycles.
        ramp_capture("sparse", 4, 10, 1);
        do_read("sparse.read");

        // Abort during POST.
        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back(i);
        k = find_trig(4, 10, 1'b1);
        arm_capture(4, 10, 1'b1);
        feed(0, k + 3, 0);
        abort = 1'b1; adc_valid = 1'b1; adc_data = DW'(stim[k + 3]);
        @(negedge clk);
        abort = 1'b0; adc_valid = 1'b0;
        chk("abort.done", done, 0);
        chk("abort.ram_we", ram_we, 0);
        chk("abort.busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("abort.nwrites", wa_q.size(), k + 3);
        base = (base + k + 3) % DEPTH;

        // rd_start in IDLE is ignored.
        rq.delete();
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_rd.n_rd_valid", rq.size(), 0);
        chk("idle_rd.busy", busy, 0);

        // Random captures.
        for (int r = 0; r < 4; r++) begin
            stim.delete();
            for (int i = 0; i < 64; i++) stim.push_back(int'($urandom_range(0, 1023)));
            pre  = int'($urandom_range(0, 15));
            lvl  = int'($urandom_range(300, 700));
            rise = 1'($urandom_range(0, 1));
            k    = find_trig(pre, lvl, rise);
            complete = (k >= 0) && (k + DEPTH - 1 - pre <= 63);
            arm_capture(pre, lvl, rise);
            feed(0, 64, 2);
            if (complete) begin
                finish_capture("rand", pre, k);
                do_read("rand.read");
            end else begin
                repeat (3) @(negedge clk);
                chk("rand_open.done", done, 0);
                chk("rand_open.busy", busy, 1);
                chk("rand_open.nwrites", wa_q.size(), 64);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                base = (base + 64) % DEPTH;
            end
        end

        // Reset mid-READ.
        ramp_capture("prerst", 4, 10, 0);
        @(negedge clk);
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("midread.rd_valid_before", rd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midread_rst.rd_valid", rd_valid, 0);
        chk("midread_rst.done", done, 0);
        chk("midread_rst.busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        base = 0;
        @(negedge clk);
        chk("post_rst.busy", busy, 0);
        chk("post_rst.done", done, 0);
        chk("post_rst.rd_valid", rd_valid, 0);

        // wr_ptr restarts at 0 after reset.
        ramp_capture("after_rst", 4, 10, 0);
        chk("after_rst.trig_addr_abs", trig_addr, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/osc_capture_ctrl.md
Name: osc_capture_ctrl

Overview:
Sequencing controller for the oscilloscope sample RAM. It streams ADC samples into the RAM as a circular buffer and holds a programmable number of pre-trigger samples. It detects a level-crossing trigger, fills the remaining post-trigger samples and then freezes the RAM. On request it reads the capture back in chronological order, oldest sample first. It sits between the ADC front end and the dual-port sample RAM, and owns the RAM's write enable and both address ports.

Parameters:
ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W samples
DATA_W, 10, ADC sample width

Ports:
clk  in  1  single system clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
arm  in  1  pulse: start a new capture
abort  in  1  pulse: return to IDLE from any state
trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
trig_level  in  DATA_W  trigger threshold, unsigned
pre_samples  in  ADDR_W  pre-trigger sample count, latched at arm
adc_valid  in  1  adc_data is valid this cycle
adc_data  in  DATA_W  ADC sample
rd_start  in  1  pulse: begin readout (accepted in DONE only)
ram_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency
ram_we  out  1  RAM write enable
ram_waddr  out  ADDR_W  RAM write address
ram_wdata  out  DATA_W  RAM write data
ram_raddr  out  ADDR_W  RAM read address
rd_valid  out  1  rd_data is valid
rd_data  out  DATA_W  readout sample
trig_addr  out  ADDR_W  RAM address of the trigger sample
done  out  1  capture complete, RAM frozen
busy  out  1  state is PRE_FILL, WAIT_TRIG, POST or READ

Behaviour:
- Reset values: state=IDLE, wr_ptr=0, all outputs 0.
- States: IDLE, PRE_FILL, WAIT_TRIG, POST, DONE, READ.
- abort has the highest priority. From any state it goes to IDLE next cycle, clears done and drops ram_we and rd_valid.
- IDLE or DONE + arm:
  - go to PRE_FILL; clear done and the prev-sample valid flag; cnt=0.
  - latch pre = min(pre_samples, DEPTH-1) and post = DEPTH-1-pre.
- arm is ignored in PRE_FILL, WAIT_TRIG, POST and READ.
- Write path, in PRE_FILL, WAIT_TRIG and POST only:
  - ram_we = adc_valid, registered together with ram_waddr = wr_ptr and ram_wdata = adc_data.
  - wr_ptr increments per accepted sample and wraps modulo DEPTH.
  - wr_ptr is not reset on arm.
- PRE_FILL:
  - count written samples; leave for WAIT_TRIG once cnt == pre (pre=0 leaves immediately).
  - trigger detection is ignored here.
- Trigger, evaluated on every accepted sample in WAIT_TRIG:
  - needs a valid prev sample.
  - rising: prev < trig_level and cur >= trig_level.
  - falling: prev > trig_level and cur <= trig_level.
  - the trigger sample is itself written; trig_addr = its address.
  - go to POST with cnt = post.
- prev sample updates on every accepted sample in PRE_FILL, WAIT_TRIG and POST.
- POST:
  - cnt decrements per accepted sample.
  - when cnt == 0 (post=0 means immediately after the trigger), go to DONE and set done=1.
  - latch start_addr = trig_addr - pre, modulo DEPTH.
- Total capture is exactly DEPTH samples: pre + 1 + post.
- DONE: no writes, adc_valid ignored, RAM frozen. rd_start goes to READ with ram_raddr = start_addr.
- READ:
  - ram_raddr increments every cycle for DEPTH addresses, wrapping.
  - rd_valid and rd_data = ram_rdata follow each address by 1 cycle; that is DEPTH contiguous rd_valid cycles, the first one cycle after the READ entry.
  - after the last address, return to DONE; done stays 1 and a re-read is allowed.
- rd_start outside DONE is ignored.
- Reset asserted mid-operation: everything returns to its reset value immediately (async); the RAM contents are don't-care.

Decomposition:
- Package osc_pkg:
  - state enum capt_state_t {IDLE, PRE_FILL, WAIT_TRIG, POST, DONE, READ}.
  - default ADDR_W and DATA_W constants.
- Sub-module osc_trig_detect: holds the prev-sample register and its valid flag, and applies the level/edge compare. Inputs: valid, data, level, rising, clear. Output: a one-cycle hit.

Test Plan:
- Override ADDR_W=4 (DEPTH=16), pre_samples=4, trig_level=10, rising, ramp 0,1,2,… one sample per cycle, arm at reset release:
  - pre-fill writes addresses 0–3; the trigger fires on value 10, so trig_addr=10.
  - post-fill writes values 11–21 to addresses 11–15 and 0–5; done=1 and start_addr=6.
  - rd_start produces ram_raddr sequence 6…15,0…5 and rd_data 6,7,…,21: 16 rd_valid cycles, starting 1 cycle after the READ entry.
- Falling trigger, level 5, data 9,8,…: the trigger fires on value 5; data starting at or below 5 (e.g. 3,2,…) never triggers and the block stays busy in WAIT_TRIG.
- pre_samples=0 and pre_samples=15:
  - pre=0: the trigger sample sits at start_addr.
  - pre=15: post=0 and done asserts the cycle after the trigger write.
- Sparse data: adc_valid toggling 1/0 pulls the sample counts at the same addresses as the dense case, and there is no write on any adc_valid=0 cycle.
- Misuse and abort:
  - abort during POST goes to IDLE next cycle with done=0 and ram_we=0.
  - arm during WAIT_TRIG is ignored.
  - rd_start in IDLE is ignored.
- rst_n pulsed low mid-READ: rd_valid, done and busy drop asynchronously, and state is IDLE after release.
